lmul_vec_pipe: RTL and testbench
================================

LMUL_VEC_PIPE -- requirements
Module: lmul_vec_pipe

Interface
REQ-001 SHALL have parameter LANES, default 4, number of independent LMUL lanes per beat.
REQ-002 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-003 SHALL have parameter MAN_W, default 7, mantissa field width; F = EXP_W+MAN_W, element width E = F+1.
REQ-004 SHALL have parameter STAGES, default 3 (legal 1..8), pipeline depth in cycles.
REQ-005 SHALL have parameter OFFSET, default 0, signed LMUL mantissa-correction constant added to every field sum.
REQ-006 SHALL have parameter TAG_W, default 4, sideband tag width.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 in_valid  in  1  input beat valid.
REQ-010 in_ready  out  1  block accepts beat this cycle.
REQ-011 in_a, in_b  in  LANES*E each  packed operands; lane i at bits [i*E +: E], sign at MSB of each element.
REQ-012 in_sat  in  1  overflow mode for this beat: 0 = all-ones field, 1 = max finite.
REQ-013 in_tag  in  TAG_W  sideband, returned unchanged with the result.
REQ-014 out_valid  out  1  result beat valid.
REQ-015 out_ready  in  1  downstream accepts beat.
REQ-016 out_bits  out  LANES*E  packed results, same lane layout as inputs.
REQ-017 out_tag  out  TAG_W  tag of the beat on out_bits.
REQ-018 ovf_cnt, unf_cnt  out  16 each  saturating per-lane-event counters.
REQ-019 cnt_clr  in  1  synchronous clear of both counters.

Function
REQ-020 Per lane: s = a.sign XOR b.sign; sum = a.field + b.field + 2^F - (BIAS<<MAN_W) + OFFSET, BIAS = 2^(EXP_W-1)-1, computed at width F+2, no truncation.
REQ-021 sum[F+1:F] = 00 → underflow, field = 0; = 01 → field = sum[F-1:0]; otherwise → overflow.
REQ-022 Overflow field SHALL be all ones when in_sat=0, and {all-ones exponent minus 1, all-ones mantissa} when in_sat=1.
REQ-023 Zero detect: if either operand's exponent field is 0, the lane result SHALL be {s, 0} and SHALL count as neither underflow nor overflow.
REQ-024 Result element SHALL be {s, field}.
REQ-025 Beat accepted when in_valid && in_ready; result appears on out_bits exactly STAGES cycles later when no stall occurs.
REQ-026 Pipeline SHALL stall globally: in_ready = !out_valid || out_ready; when stalled, every stage holds its contents and no beat is lost or duplicated.
REQ-027 Bubbles SHALL propagate; a full pipeline with out_ready held high SHALL sustain one beat per cycle.
REQ-028 out_bits and out_tag SHALL remain stable while out_valid && !out_ready.
REQ-029 in_sat and in_tag SHALL travel with their beat through every stage.
REQ-030 Counters SHALL increment by the number of overflowing/underflowing lanes in a beat at the cycle that beat is accepted downstream (out_valid && out_ready), and SHALL saturate at 0xFFFF.
REQ-031 cnt_clr SHALL take priority over a simultaneous increment; the counter reads 0 on the following cycle.

Reset
REQ-032 rst_n low SHALL asynchronously clear all stage valid bits, out_valid=0, ovf_cnt=0, unf_cnt=0; out_bits and out_tag SHALL reset to 0.
REQ-033 in_ready SHALL be 1 during and after reset.
REQ-034 Reset mid-operation SHALL discard all in-flight beats; no result SHALL emerge for them after release.

Structure
REQ-035 BIAS, E, F, the overflow constants and the lane-field helper function SHALL reside in a shared package lmul_pkg.
REQ-036 Per-lane arithmetic SHALL be a sub-module lmul_lane (combinational core with registered output), instantiated LANES times; the handshake/stall control and counters SHALL reside in lmul_vec_pipe.

Verification (BF16 defaults, lane 0 shown, other lanes 0x3F80)
REQ-037 a=0x3F80, b=0x3F80, in_sat=0 → 0x3F80 after 3 cycles; a=0x4000, b=0x4040 → 0x40C0; a=0xC000, b=0x4040 → 0xC0C0.
REQ-038 a=0x7F00, b=0x7F00: in_sat=0 → 0x7FFF, in_sat=1 → 0x7F7F; ovf_cnt = 1 per beat.
REQ-039 a=0x0080, b=0x0080 → 0x0000 and unf_cnt +1; a=0x0000, b=0x4000 → 0x0000 with no counter change.
REQ-040 Stream 10 beats with tags 0..9 while out_ready toggles pseudo-randomly → all 10 results in order, each with the correct tag, output stable across stalls.
REQ-041 Assert rst_n low with 3 beats in flight → out_valid=0 immediately; no stale beat after release; counters read 0.
REQ-042 Force 0xFFFF overflow events → ovf_cnt holds at 0xFFFF; cnt_clr together with an overflow beat → 0.

Source files
------------

// File: rtl/lmul_pkg.sv
// lmul_pkg: constants and helpers shared by the LMUL vector pipeline.
//   Default element format is BF16: 1 sign bit, 8 exponent bits, 7 mantissa bits.
//   F/E/BIAS/OVF_* describe that default format. The helper functions take the
//   exponent and mantissa widths as arguments, so a non-default instance can use
//   the same code. The helpers work in 32-bit arithmetic, so F must be below 32.
package lmul_pkg;

    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 7;
    localparam int F         = EXP_W_DEF + MAN_W_DEF;
    localparam int E         = F + 1;
    localparam int BIAS      = (1 << (EXP_W_DEF - 1)) - 1;

    // Overflow fields: all ones (sat=0), or largest finite value (sat=1).
    localparam logic [F-1:0] OVF_INF = '1;
    localparam logic [F-1:0] OVF_MAX = {{(EXP_W_DEF-1){1'b1}}, 1'b0, {MAN_W_DEF{1'b1}}};

    function automatic int bias_of(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Constant added to a.field + b.field. The 2^F term keeps the sum
    // non-negative for any legal operand pair.
    function automatic int sum_const(input int exp_w, input int man_w, input int offset);
        return (1 << (exp_w + man_w)) - (bias_of(exp_w) << man_w) + offset;
    endfunction

    // Maps the top two sum bits and the low F bits to the result field.
    //   00 -> underflow (0)
    //   01 -> in range
    //   1x -> overflow
    function automatic logic [31:0] lane_field(input int exp_w, input int man_w,
                                               input logic [1:0] top, input logic [31:0] low,
                                               input logic sat);
        logic [31:0] ones;
        logic [31:0] fld;
        ones = (32'd1 << (exp_w + man_w)) - 32'd1;
        case (top)
            2'b00:   fld = '0;
            2'b01:   fld = low & ones;
            default: fld = sat ? (ones - (32'd1 << man_w)) : ones;
        endcase
        return fld;
    endfunction

endpackage

// File: rtl/lmul_lane.sv
// lmul_lane: one LMUL lane. The combinational multiply core feeds an output
//   register that is enabled by the global pipeline advance.
//   clk, rst_n   clock, async active-low reset
//   en           pipeline advance (hold when low)
//   a_i, b_i     operand elements {sign, exp, man}
//   sat_i        overflow mode of this beat
//   res_o        registered result element
//   ovf_o        registered overflow flag for this lane
//   unf_o        registered underflow flag for this lane
module lmul_lane import lmul_pkg::*; #(
    parameter int EXP_W  = EXP_W_DEF,
    parameter int MAN_W  = MAN_W_DEF,
    parameter int OFFSET = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [EXP_W+MAN_W:0]   a_i,
    input  logic [EXP_W+MAN_W:0]   b_i,
    input  logic                   sat_i,
    output logic [EXP_W+MAN_W:0]   res_o,
    output logic                   ovf_o,
    output logic                   unf_o
);

    localparam int FW = EXP_W + MAN_W;
    localparam logic [FW+1:0] K = (FW+2)'(sum_const(EXP_W, MAN_W, OFFSET));

    logic          sign, zero;
    logic [FW+1:0] sum;
    logic [FW:0]   res_d, res_q;
    logic          ovf_d, ovf_q, unf_d, unf_q;

    always_comb begin
        sign  = a_i[FW] ^ b_i[FW];
        // An operand with a zero exponent forces a signed zero and counts no event.
        zero  = (a_i[FW-1:MAN_W] == '0) || (b_i[FW-1:MAN_W] == '0);
        sum   = {2'b00, a_i[FW-1:0]} + {2'b00, b_i[FW-1:0]} + K;
        res_d = zero ? {sign, {FW{1'b0}}}
                     : {sign, FW'(lane_field(EXP_W, MAN_W, sum[FW+1:FW], 32'(sum[FW-1:0]), sat_i))};
        ovf_d = !zero && sum[FW+1];
        unf_d = !zero && (sum[FW+1:FW] == 2'b00);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (en) begin
            res_q <= res_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign res_o = res_q;
    assign ovf_o = ovf_q;
    assign unf_o = unf_q;

endmodule

// File: rtl/lmul_vec_pipe.sv
// lmul_vec_pipe: LANES-wide LMUL multiplier with a pipeline of STAGES cycles.
//   The whole pipeline stalls together through a ready/valid handshake.
//   in_valid/in_ready            input beat handshake
//   in_a, in_b                   packed operands, lane i at [i*E +: E]
//   in_sat, in_tag               per-beat overflow mode and sideband tag
//   out_valid/out_ready          output beat handshake
//   out_bits, out_tag            result beat and its tag
//   ovf_cnt, unf_cnt             saturating counts of lane overflow/underflow events
//   cnt_clr                      synchronous clear of both counters; wins over an increment
// Operands travel through STAGES-1 delay registers. The lanes compute at the
// last stage into their own output registers.
module lmul_vec_pipe import lmul_pkg::*; #(
    parameter int LANES  = 4,
    parameter int EXP_W  = EXP_W_DEF,
    parameter int MAN_W  = MAN_W_DEF,
    parameter int STAGES = 3,
    parameter int OFFSET = 0,
    parameter int TAG_W  = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [LANES*(EXP_W+MAN_W+1)-1:0] in_a,
    input  logic [LANES*(EXP_W+MAN_W+1)-1:0] in_b,
    input  logic                             in_sat,
    input  logic [TAG_W-1:0]                 in_tag,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [LANES*(EXP_W+MAN_W+1)-1:0] out_bits,
    output logic [TAG_W-1:0]                 out_tag,
    output logic [15:0]                      ovf_cnt,
    output logic [15:0]                      unf_cnt,
    input  logic                             cnt_clr
);

    localparam int EW = EXP_W + MAN_W + 1;
    localparam int CW = $clog2(LANES + 1);

    typedef struct packed {
        logic [LANES*EW-1:0] a;
        logic [LANES*EW-1:0] b;
        logic                sat;
        logic [TAG_W-1:0]    tag;
    } beat_t;

    logic        adv;
    beat_t       in_beat, src;
    logic [STAGES:0] vld_pipe;
    logic [STAGES:1] vld_q;

    // Every stage moves together whenever the output slot is empty or being drained.
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign in_beat   = {in_a, in_b, in_sat, in_tag};
    assign vld_pipe  = {vld_q, in_valid};
    assign out_valid = vld_pipe[STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   vld_q <= '0;
        else if (adv) vld_q <= vld_pipe[STAGES-1:0];
    end

    if (STAGES == 1) begin : g_nodly
        assign src = in_beat;
    end else begin : g_dly
        beat_t dly_q [STAGES-1];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s < STAGES-1; s++) dly_q[s] <= '0;
            end else if (adv) begin
                dly_q[0] <= in_beat;
                for (int s = 1; s < STAGES-1; s++) dly_q[s] <= dly_q[s-1];
            end
        end
        assign src = dly_q[STAGES-2];
    end

    logic [LANES-1:0][EW-1:0] res;
    logic [LANES-1:0]         ovf, unf;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        lmul_lane #(.EXP_W(EXP_W), .MAN_W(MAN_W), .OFFSET(OFFSET)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (adv),
            .a_i   (src.a[i*EW +: EW]),
            .b_i   (src.b[i*EW +: EW]),
            .sat_i (src.sat),
            .res_o (res[i]),
            .ovf_o (ovf[i]),
            .unf_o (unf[i])
        );
    end

    logic [TAG_W-1:0] tag_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   tag_q <= '0;
        else if (adv) tag_q <= src.tag;
    end

    assign out_bits = res;
    assign out_tag  = tag_q;

    // Event counters update on the downstream handshake and saturate at 0xFFFF.
    logic          fire;
    logic [CW-1:0] n_ovf, n_unf;
    logic [16:0]   ovf_sum, unf_sum;
    logic [15:0]   ovf_d, ovf_q, unf_d, unf_q;

    assign fire = out_valid && out_ready;

    always_comb begin
        n_ovf = '0;
        n_unf = '0;
        for (int i = 0; i < LANES; i++) begin
            n_ovf += CW'(ovf[i] & fire);
            n_unf += CW'(unf[i] & fire);
        end
        ovf_sum = {1'b0, ovf_q} + 17'(n_ovf);
        unf_sum = {1'b0, unf_q} + 17'(n_unf);
        ovf_d   = cnt_clr ? 16'h0 : (ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0]);
        unf_d   = cnt_clr ? 16'h0 : (unf_sum[16] ? 16'hFFFF : unf_sum[15:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= '0;
            unf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign ovf_cnt = ovf_q;
    assign unf_cnt = unf_q;

endmodule

// File: tb/tb_lmul_vec_pipe.sv
// tb_lmul_vec_pipe: directed checks of lmul_vec_pipe with the BF16 defaults.
//   Inputs are driven 1 time unit after a rising edge. Outputs are read at the
//   same point, or on the falling edge in the handshake stream test.
module tb_lmul_vec_pipe;

    localparam int LANES = 4;
    localparam int EW    = 16;
    localparam int TAG_W = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [LANES*EW-1:0]   in_a = '0;
    logic [LANES*EW-1:0]   in_b = '0;
    logic                  in_sat = 1'b0;
    logic [TAG_W-1:0]      in_tag = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic [LANES*EW-1:0]   out_bits;
    logic [TAG_W-1:0]      out_tag;
    logic [15:0]           ovf_cnt, unf_cnt;
    logic                  cnt_clr = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lmul_vec_pipe #(.LANES(LANES), .EXP_W(8), .MAN_W(7), .STAGES(3), .OFFSET(0), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sat(in_sat), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits), .out_tag(out_tag),
        .ovf_cnt(ovf_cnt), .unf_cnt(unf_cnt), .cnt_clr(cnt_clr)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Sends one beat with lane 0 = a0*b0 and the other lanes = 1.0*1.0.
    // Returns when the result appears, or after 20 cycles.
    task automatic drive_beat(input logic [15:0] a0, input logic [15:0] b0, input logic sat,
                              input logic [3:0] tag, output logic [63:0] bits,
                              output logic [3:0] tg, output int lat);
        in_a = {{3{16'h3F80}}, a0};
        in_b = {{3{16'h3F80}}, b0};
        in_sat = sat; in_tag = tag; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        bits = out_bits; tg = out_tag;
    endtask

    task automatic test_reset();
        #3;
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_chk++; if (out_bits !== 64'h0 || out_tag !== 4'h0) begin n_fail++; $display("FAIL reset_out_data: got %h/%h want 0/0", out_bits, out_tag); end
        n_chk++; if (ovf_cnt !== 16'h0 || unf_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_counters: got %h/%h want 0/0", ovf_cnt, unf_cnt); end
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        logic [63:0] bits; logic [3:0] tg; int lat;
        drive_beat(16'h3F80, 16'h3F80, 1'b0, 4'h1, bits, tg, lat);
        n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL latency: got %0d want 3", lat); end
        n_chk++; if (bits[15:0] !== 16'h3F80) begin n_fail++; $display("FAIL one_x_one: got %h want 3f80", bits[15:0]); end
        n_chk++; if (bits[63:16] !== {3{16'h3F80}} || tg !== 4'h1) begin n_fail++; $display("FAIL upper_lanes_tag: got %h/%h want 3f803f803f80/1", bits[63:16], tg); end
        @(posedge clk); #1;
        drive_beat(16'h4000, 16'h4040, 1'b0, 4'h2, bits, tg, lat);
        n_chk++; if (bits[15:0] !== 16'h40C0) begin n_fail++; $display("FAIL two_x_three: got %h want 40c0", bits[15:0]); end
        @(posedge clk); #1;
        drive_beat(16'hC000, 16'h4040, 1'b0, 4'h3, bits, tg, lat);
        n_chk++; if (bits[15:0] !== 16'hC0C0) begin n_fail++; $display("FAIL neg_two_x_three: got %h want c0c0", bits[15:0]); end
        @(posedge clk); #1;
    endtask

    task automatic test_ovf();
        logic [63:0] bits; logic [3:0] tg; int lat;
        drive_beat(16'h7F00, 16'h7F00, 1'b0, 4'h4, bits, tg, lat);
        n_chk++; if (bits[15:0] !== 16'h7FFF) begin n_fail++; $display("FAIL ovf_inf: got %h want 7fff", bits[15:0]); end
        @(posedge clk); #1;
        n_chk++; if (ovf_cnt !== 16'd1) begin n_fail++; $display("FAIL ovf_cnt_1: got %0d want 1", ovf_cnt); end
        drive_beat(16'h7F00, 16'h7F00, 1'b1, 4'h5, bits, tg, lat);
        n_chk++; if (bits[15:0] !== 16'h7F7F) begin n_fail++; $display("FAIL ovf_sat: got %h want 7f7f", bits[15:0]); end
        @(posedge clk); #1;
        n_chk++; if (ovf_cnt !== 16'd2 || unf_cnt !== 16'd0) begin n_fail++; $display("FAIL ovf_cnt_2: got %0d/%0d want 2/0", ovf_cnt, unf_cnt); end
    endtask

    task automatic test_unf_zero();
        logic [63:0] bits; logic [3:0] tg; int lat;
        drive_beat(16'h0080, 16'h0080, 1'b0, 4'h6, bits, tg, lat);
        n_chk++; if (bits[15:0] !== 16'h0000) begin n_fail++; $display("FAIL unf_result: got %h want 0000", bits[15:0]); end
        @(posedge clk); #1;
        n_chk++; if (unf_cnt !== 16'd1) begin n_fail++; $display("FAIL unf_cnt: got %0d want 1", unf_cnt); end
        drive_beat(16'h0000, 16'h4000, 1'b0, 4'h7, bits, tg, lat);
        n_chk++; if (bits[15:0] !== 16'h0000) begin n_fail++; $display("FAIL zero_result: got %h want 0000", bits[15:0]); end
        @(posedge clk); #1;
        drive_beat(16'h8000, 16'h4000, 1'b0, 4'h8, bits, tg, lat);
        n_chk++; if (bits[15:0] !== 16'h8000) begin n_fail++; $display("FAIL neg_zero_result: got %h want 8000", bits[15:0]); end
        @(posedge clk); #1;
        n_chk++; if (ovf_cnt !== 16'd2 || unf_cnt !== 16'd1) begin n_fail++; $display("FAIL zero_no_count: got %0d/%0d want 2/1", ovf_cnt, unf_cnt); end
    endtask

    task automatic test_stream();
        logic [15:0] exp_lane0 [10];
        for (int k = 0; k < 10; k++)
            exp_lane0[k] = ((k % 2 == 1) ? 16'h8000 : 16'h0000) | (16'h4000 + 16'(k * 16));
        fork
            begin : producer
                logic acc; int guard;
                for (int k = 0; k < 10; k++) begin
                    in_a = {{3{16'h3F80}}, ((k % 2 == 1) ? 16'hBF80 : 16'h3F80)};
                    in_b = {{3{16'h3F80}}, 16'h4000 + 16'(k * 16)};
                    in_tag = 4'(k); in_sat = 1'b0; in_valid = 1'b1;
                    acc = 1'b0; guard = 0;
                    while (!acc && guard < 200) begin
                        @(negedge clk); acc = in_ready;
                        @(posedge clk); #1; guard++;
                    end
                    in_valid = 1'b0;
                    if (k == 4) begin @(posedge clk); #1; end
                end
            end
            begin : consumer
                logic [63:0] held; logic [3:0] held_t; logic held_v; int got, cyc;
                got = 0; cyc = 0; held_v = 1'b0; held = '0; held_t = '0;
                while (got < 10 && cyc < 400) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                    @(negedge clk); cyc++;
                    if (held_v) begin
                        n_chk++;
                        if (out_valid !== 1'b1 || out_bits !== held || out_tag !== held_t) begin
                            n_fail++; $display("FAIL stall_stable: got %b/%h/%h want 1/%h/%h", out_valid, out_bits, out_tag, held, held_t);
                        end
                    end
                    held_v = 1'b0;
                    if (out_valid) begin
                        if (out_ready) begin
                            n_chk++; if (out_bits[15:0] !== exp_lane0[got]) begin n_fail++; $display("FAIL stream_data[%0d]: got %h want %h", got, out_bits[15:0], exp_lane0[got]); end
                            n_chk++; if (out_tag !== 4'(got)) begin n_fail++; $display("FAIL stream_tag[%0d]: got %h want %h", got, out_tag, 4'(got)); end
                            got++;
                        end else begin
                            held = out_bits; held_t = out_tag; held_v = 1'b1;
                        end
                    end
                end
                n_chk++; if (got !== 10) begin n_fail++; $display("FAIL stream_count: got %0d want 10", got); end
            end
        join
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (ovf_cnt !== 16'd2 || unf_cnt !== 16'd1) begin n_fail++; $display("FAIL stream_counters: got %0d/%0d want 2/1", ovf_cnt, unf_cnt); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        in_a = {4{16'h7F00}}; in_b = {4{16'h7F00}}; in_sat = 1'b0; in_valid = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        rst_n = 1'b0; #1;
        n_chk++; if (out_valid !== 1'b0 || out_bits !== 64'h0) begin n_fail++; $display("FAIL mid_reset_out: got %b/%h want 0/0", out_valid, out_bits); end
        n_chk++; if (ovf_cnt !== 16'h0 || unf_cnt !== 16'h0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_cnt_rdy: got %h/%h/%b want 0/0/1", ovf_cnt, unf_cnt, in_ready); end
        @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        n_chk++; if (seen !== 1'b0 || ovf_cnt !== 16'h0) begin n_fail++; $display("FAIL stale_beat: got seen=%b ovf=%h want 0/0", seen, ovf_cnt); end
    endtask

    task automatic test_cnt_sat();
        int lat;
        in_a = {4{16'h7F00}}; in_b = {4{16'h7F00}}; in_sat = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1; @(posedge clk); #1;
        n_chk++; if (out_valid !== 1'b1 || out_bits !== {4{16'h7F7F}}) begin n_fail++; $display("FAIL all_lane_sat: got %b/%h want 1/7f7f7f7f7f7f7f7f", out_valid, out_bits); end
        @(posedge clk); #1;
        n_chk++; if (ovf_cnt !== 16'd4) begin n_fail++; $display("FAIL multi_lane_ovf: got %0d want 4", ovf_cnt); end
        in_valid = 1'b1;
        repeat (16400) @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        n_chk++; if (ovf_cnt !== 16'hFFFF || unf_cnt !== 16'h0) begin n_fail++; $display("FAIL ovf_saturate: got %h/%h want ffff/0", ovf_cnt, unf_cnt); end
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        n_chk++; if (ovf_cnt !== 16'h0) begin n_fail++; $display("FAIL clr_priority: got %h want 0", ovf_cnt); end
        @(posedge clk); #1;
        n_chk++; if (ovf_cnt !== 16'h0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_after: got %h/%b want 0/0", ovf_cnt, out_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ovf();
        test_unf_zero();
        test_stream();
        test_reset_mid();
        test_cnt_sat();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
